immediate_gen: RTL and testbench
================================

Name: immediate_gen

Overview:
- Extracts and sign-extends the RV64I immediates from a 32-bit instruction word. Sits between instruction fetch and execute in the mini-cpu.
- Per-format immediates are purely combinational, with zero latency.
- Also provides one opcode-selected immediate and a registered copy of it for the pipelined datapath.

Parameters:
- xlen, 64, datapath width. Width of instr and of all immediate outputs; must be at least 32.

Ports:
- clk  input  1  system clock; only the registered outputs use it
- rst  input  1  synchronous, active-high reset
- instr  input  xlen  instruction word; only bits [31:0] are decoded, bits [xlen-1:32] are ignored
- imm_mem  output  xlen  load/store offset: S-type if opcode is STORE, otherwise I-type
- imm_branch  output  xlen  B-type branch offset, in bytes
- imm_alu  output  xlen  I-type immediate
- imm_upper  output  xlen  U-type immediate
- imm_jump  output  xlen  J-type jump offset, in bytes
- imm_sel  output  xlen  immediate selected by opcode, combinational
- fmt  output  3  format code, combinational: 0=none, 1=I, 2=S, 3=B, 4=U, 5=J
- imm_q  output  xlen  imm_sel registered on clk
- fmt_q  output  3  fmt registered on clk

Behaviour:
- All sign extension replicates instr[31] up to bit xlen-1.
- I-type = sext(instr[31:20]).
- S-type = sext({instr[31:25], instr[11:7]}).
- B-type = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}); bit 0 is always 0.
- U-type = sext({instr[31:12], 12'b0}).
- J-type = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- imm_mem: S-type when instr[6:0]=0100011, otherwise I-type.
- imm_branch, imm_alu, imm_upper and imm_jump are computed from every instruction regardless of opcode.
- Outputs are valid in the same delta as the instr change; there is no clock dependency.
- fmt decode from opcode instr[6:0]:
  - 0000011, 0010011, 0011011, 1100111, 1110011 -> I
  - 0100011 -> S
  - 1100011 -> B
  - 0110111, 0010111 -> U
  - 1101111 -> J
  - any other opcode (R-type, illegal) -> none
- imm_sel is the immediate matching fmt; when fmt=none, imm_sel=0.
- Shift-immediate instructions (funct3 001/101 under OP-IMM) still produce the full I-type value; downstream logic masks shamt.
- Registered path:
  - On a rising clk edge with rst=1: imm_q<=0 and fmt_q<=0.
  - Otherwise: imm_q<=imm_sel and fmt_q<=fmt. Latency is one cycle.
- Combinational outputs are unaffected by rst.
- No handshake and no stall: the registered path captures every cycle.
- No X propagation on defined inputs: all outputs are fully defined for any 32-bit pattern.

Decomposition:
- Shared package `rv_isa_pkg` holds:
  - opcode constants: LOAD, OP_IMM, OP_IMM_32, JALR, SYSTEM, STORE, BRANCH, LUI, AUIPC, JAL
  - the 3-bit fmt enumeration
- One sub-module is natural: `imm_extract` (combinational, parameter xlen), producing the five per-format immediates.
- immediate_gen instantiates imm_extract, then adds the opcode decode, the selection mux and the output register.

Test Plan:
- instr=0x02208463 (beq x1,x2,40) -> imm_branch=40, fmt=3, imm_sel=40; next clk imm_q=40.
- instr=0xfe628ce3 (beq x5,x6,-8) -> imm_branch=-8 (0xFFFF_FFFF_FFFF_FFF8).
- instr=0x02213103 (ld x2,34(x2)) -> imm_mem=34, fmt=1.
- instr=0xec62ba23 (sd x6,-300(x5)) -> imm_mem=-300, fmt=2.
- U- and J-type checks:
  - instr=0x123450b7 (lui x1,0x12345) -> imm_upper=0x12345000, fmt=4.
  - instr=0xffdff0ef (jal x1,-4) -> imm_jump=-4, fmt=5.
- Reset and undecoded opcode:
  - Hold rst=1 for one clk with any instr -> imm_q=0 and fmt_q=0, while imm_sel still tracks instr.
  - instr=0x002081b3 (add, R-type) -> fmt=0 and imm_sel=0.

Source files
------------

// File: rtl/rv_isa_pkg.sv
// Shared RV64I ISA definitions: base opcodes and the immediate-format code
// used by the decode stage of the mini-cpu.
package rv_isa_pkg;

    // Base opcodes (instr[6:0]) that carry an immediate.
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] SYSTEM    = 7'b1110011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] JAL       = 7'b1101111;

    // Immediate format code; the numeric values are visible on the fmt port.
    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

    // Map an opcode to its immediate format. R-type and anything not listed
    // has no immediate and reports FMT_NONE.
    function automatic fmt_e opcode_to_fmt(input logic [6:0] opcode);
        fmt_e result;
        result = FMT_NONE;
        case (opcode)
            LOAD, OP_IMM, OP_IMM_32, JALR, SYSTEM: result = FMT_I;
            STORE:                                 result = FMT_S;
            BRANCH:                                result = FMT_B;
            LUI, AUIPC:                            result = FMT_U;
            JAL:                                   result = FMT_J;
            default:                               result = FMT_NONE;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational extraction of the five RV64I immediate formats. Every format
// is produced for every instruction; choosing the right one is left to the
// caller. All values are sign-extended from instr[31] up to xlen bits.
module imm_extract #(
    parameter int xlen = 64
) (
    input  logic [31:7]     word,
    output logic [xlen-1:0] imm_i,
    output logic [xlen-1:0] imm_s,
    output logic [xlen-1:0] imm_b,
    output logic [xlen-1:0] imm_u,
    output logic [xlen-1:0] imm_j
);

    // Raw immediate fields reassembled in their natural bit order before
    // sign extension. The opcode bits are not needed here, hence the port
    // starts at bit 7.
    logic [11:0] raw_i;
    logic [11:0] raw_s;
    logic [12:0] raw_b;
    logic [31:0] raw_u;
    logic [20:0] raw_j;

    // Gather the scattered instruction fields into contiguous immediates.
    always_comb begin
        raw_i = word[31:20];
        raw_s = {word[31:25], word[11:7]};
        raw_b = {word[31], word[7], word[30:25], word[11:8], 1'b0};
        raw_u = {word[31:12], 12'b0};
        raw_j = {word[31], word[19:12], word[20], word[30:21], 1'b0};
    end

    // Sign-extend each field to the datapath width; a size cast of a signed
    // value replicates its top bit, which is instr[31] in every format.
    always_comb begin
        imm_i = xlen'($signed(raw_i));
        imm_s = xlen'($signed(raw_s));
        imm_b = xlen'($signed(raw_b));
        imm_u = xlen'($signed(raw_u));
        imm_j = xlen'($signed(raw_j));
    end

endmodule

// File: rtl/immediate_gen.sv
// Immediate generator between fetch and execute: per-format immediates,
// an opcode-selected immediate with its format code, and a one-cycle
// registered copy of the selection for the pipelined datapath.
module immediate_gen
    import rv_isa_pkg::*;
#(
    parameter int xlen = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [xlen-1:0] instr,
    output logic [xlen-1:0] imm_mem,
    output logic [xlen-1:0] imm_branch,
    output logic [xlen-1:0] imm_alu,
    output logic [xlen-1:0] imm_upper,
    output logic [xlen-1:0] imm_jump,
    output logic [xlen-1:0] imm_sel,
    output logic [2:0]      fmt,
    output logic [xlen-1:0] imm_q,
    output logic [2:0]      fmt_q
);

    logic [xlen-1:0] imm_i;
    logic [xlen-1:0] imm_s;
    logic [xlen-1:0] imm_b;
    logic [xlen-1:0] imm_u;
    logic [xlen-1:0] imm_j;
    logic [6:0]      opcode;
    fmt_e            fmt_dec;

    // Only the low 32 bits form an instruction; the upper bits are ignored.
    generate
        if (xlen > 32) begin : g_upper
            logic unused_upper_bits;
            assign unused_upper_bits = ^instr[xlen-1:32];
        end
    endgenerate

    assign opcode = instr[6:0];

    imm_extract #(
        .xlen (xlen)
    ) u_extract (
        .word  (instr[31:7]),
        .imm_i (imm_i),
        .imm_s (imm_s),
        .imm_b (imm_b),
        .imm_u (imm_u),
        .imm_j (imm_j)
    );

    // Per-format outputs; the memory offset switches to S-type only for stores
    // so that loads and everything else see the I-type field.
    always_comb begin
        imm_alu    = imm_i;
        imm_branch = imm_b;
        imm_upper  = imm_u;
        imm_jump   = imm_j;
        imm_mem    = (opcode == STORE) ? imm_s : imm_i;
    end

    // Decode the opcode into a format code.
    always_comb begin
        fmt_dec = opcode_to_fmt(opcode);
        fmt     = fmt_dec;
    end

    // Pick the immediate matching the decoded format; no format means zero.
    always_comb begin
        imm_sel = '0;
        case (fmt_dec)
            FMT_I:   imm_sel = imm_i;
            FMT_S:   imm_sel = imm_s;
            FMT_B:   imm_sel = imm_b;
            FMT_U:   imm_sel = imm_u;
            FMT_J:   imm_sel = imm_j;
            default: imm_sel = '0;
        endcase
    end

    // Pipeline register: captures the selection every cycle, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            imm_q <= '0;
            fmt_q <= 3'd0;
        end else begin
            imm_q <= imm_sel;
            fmt_q <= fmt;
        end
    end

endmodule

// File: tb/tb_immediate_gen.sv
// Self-checking bench for immediate_gen: directed instructions plus random
// words, compared against an arithmetic reference model. The registered path
// is checked through a scoreboard queue drained by an independent monitor.
module tb_immediate_gen;

    localparam int XLEN = 64;

    logic            clk;
    logic            rst;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] imm_mem;
    logic [XLEN-1:0] imm_branch;
    logic [XLEN-1:0] imm_alu;
    logic [XLEN-1:0] imm_upper;
    logic [XLEN-1:0] imm_jump;
    logic [XLEN-1:0] imm_sel;
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm_q;
    logic [2:0]      fmt_q;

    int checks = 0;
    int errors = 0;

    // Scoreboard entry layout: {fmt[2:0], imm[63:0]}
    logic [66:0] exp_queue[$];

    immediate_gen #(
        .xlen (XLEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .imm_mem    (imm_mem),
        .imm_branch (imm_branch),
        .imm_alu    (imm_alu),
        .imm_upper  (imm_upper),
        .imm_jump   (imm_jump),
        .imm_sel    (imm_sel),
        .fmt        (fmt),
        .imm_q      (imm_q),
        .fmt_q      (fmt_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each immediate is built as a signed integer from the
    // weighted value of each instruction field.
    function automatic logic [63:0] modelI(input logic [31:0] w);
        longint v;
        v = int'(w);
        return v >>> 20;
    endfunction

    function automatic logic [63:0] modelS(input logic [31:0] w);
        longint v;
        v = int'(w);
        return (v >>> 25) * 32 + longint'(w[11:7]);
    endfunction

    function automatic logic [63:0] modelB(input logic [31:0] w);
        longint v;
        v = w[31] ? -64'sd4096 : 64'sd0;
        v = v + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
        return v;
    endfunction

    function automatic logic [63:0] modelU(input logic [31:0] w);
        longint v;
        v = int'(w & 32'hFFFF_F000);
        return v;
    endfunction

    function automatic logic [63:0] modelJ(input logic [31:0] w);
        longint v;
        v = w[31] ? -64'sd1048576 : 64'sd0;
        v = v + longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
        return v;
    endfunction

    function automatic logic [2:0] modelFmt(input logic [31:0] w);
        case (w[6:0])
            7'h03, 7'h13, 7'h1B, 7'h67, 7'h73: return 3'd1;
            7'h23:                             return 3'd2;
            7'h63:                             return 3'd3;
            7'h37, 7'h17:                      return 3'd4;
            7'h6F:                             return 3'd5;
            default:                           return 3'd0;
        endcase
    endfunction

    function automatic logic [63:0] modelSel(input logic [31:0] w);
        case (modelFmt(w))
            3'd1:    return modelI(w);
            3'd2:    return modelS(w);
            3'd3:    return modelB(w);
            3'd4:    return modelU(w);
            3'd5:    return modelJ(w);
            default: return 64'd0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", name, actual, expected);
        end
    endtask

    // Drive one instruction just after a rising edge, queue the value the
    // register should show after the next edge, then check the combinational
    // outputs once they have settled.
    task automatic applyStimulus(input logic [63:0] w, input logic r);
        logic [31:0] lo;
        @(posedge clk);
        #2;
        instr = w;
        rst   = r;
        lo    = w[31:0];
        if (r) exp_queue.push_back({3'd0, 64'd0});
        else   exp_queue.push_back({modelFmt(lo), modelSel(lo)});
        #1;
        checkOutput("imm_alu",    imm_alu,    modelI(lo));
        checkOutput("imm_branch", imm_branch, modelB(lo));
        checkOutput("imm_upper",  imm_upper,  modelU(lo));
        checkOutput("imm_jump",   imm_jump,   modelJ(lo));
        checkOutput("imm_mem",    imm_mem,    (lo[6:0] == 7'h23) ? modelS(lo) : modelI(lo));
        checkOutput("imm_sel",    imm_sel,    modelSel(lo));
        checkOutput("fmt",        {61'd0, fmt}, {61'd0, modelFmt(lo)});
    endtask

    // Monitor: shortly after every rising edge the register holds the value
    // captured from the previous cycle's stimulus.
    initial begin : monitor
        logic [66:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_queue.size() > 0) begin
                e = exp_queue.pop_front();
                checkOutput("imm_q", imm_q, e[63:0]);
                checkOutput("fmt_q", {61'd0, fmt_q}, {61'd0, e[66:64]});
            end
        end
    end

    // Opcodes used to steer random stimulus toward every format.
    logic [6:0] opcode_pool [12] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23,
                                     7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

    // Directed test-plan instructions, then randomized words.
    initial begin : stimulus
        logic [63:0] w;
        int guard;
        instr = '0;
        rst   = 1'b1;

        // Reset held with a live instruction: register cleared, selection live.
        applyStimulus(64'h0000_0000_0220_8463, 1'b1);
        checkOutput("rst_sel_tracks", imm_sel, 64'd40);
        applyStimulus(64'h0000_0000_0220_8463, 1'b0);
        checkOutput("beq40_branch", imm_branch, 64'd40);
        checkOutput("beq40_fmt", {61'd0, fmt}, 64'd3);
        checkOutput("rst_imm_q", imm_q, 64'd0);
        applyStimulus(64'h0000_0000_fe62_8ce3, 1'b0);
        checkOutput("beq40_imm_q", imm_q, 64'd40);
        checkOutput("beq_m8_branch", imm_branch, 64'hFFFF_FFFF_FFFF_FFF8);
        applyStimulus(64'h0000_0000_0221_3103, 1'b0);
        checkOutput("ld_mem", imm_mem, 64'd34);
        checkOutput("ld_fmt", {61'd0, fmt}, 64'd1);
        applyStimulus(64'h0000_0000_ec62_ba23, 1'b0);
        checkOutput("sd_mem", imm_mem, 64'hFFFF_FFFF_FFFF_FED4);
        checkOutput("sd_fmt", {61'd0, fmt}, 64'd2);
        applyStimulus(64'hDEAD_BEEF_1234_50b7, 1'b0);
        checkOutput("lui_upper", imm_upper, 64'h0000_0000_1234_5000);
        checkOutput("lui_fmt", {61'd0, fmt}, 64'd4);
        applyStimulus(64'h0000_0000_ffdf_f0ef, 1'b0);
        checkOutput("jal_jump", imm_jump, 64'hFFFF_FFFF_FFFF_FFFC);
        checkOutput("jal_fmt", {61'd0, fmt}, 64'd5);
        applyStimulus(64'h0000_0000_0020_81b3, 1'b0);
        checkOutput("add_fmt", {61'd0, fmt}, 64'd0);
        checkOutput("add_sel", imm_sel, 64'd0);
        applyStimulus(64'h0000_0000_8000_0013, 1'b0);
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

        for (int i = 0; i < 400; i++) begin
            w = {$urandom, $urandom};
            if ($urandom_range(3) != 0) w[6:0] = opcode_pool[$urandom_range(11)];
            applyStimulus(w, ($urandom_range(9) == 0));
        end

        guard = 0;
        while (exp_queue.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #3;
        checks++;
        if (exp_queue.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", exp_queue.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
